// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes.
// Define SEQ_WDOG_EN to add the memory-request watchdog and fault flag.
`ifndef W_MEM_CMD
`define W_MEM_CMD 2
`define MEM_NOP   2'd0
`define MEM_READ  2'd1
`define MEM_WRITE 2'd2
`define WREN      1'b1
`define WDIS      1'b0
`endif

module cpu_sequencer #(
    parameter int W_INSTRET = 32
`ifdef SEQ_WDOG_EN
    ,
    parameter int MEM_TIMEOUT = 255
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  halt_dec,
    input  logic [`W_MEM_CMD-1:0] mem_cmd,
    input  logic                  reg_wen_dec,
    input  logic                  imem_ready,
    input  logic                  dmem_ready,
    output logic                  imem_req,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic                  ir_en,
    output logic                  pc_en,
    output logic                  reg_wen,
    output logic                  halted,
    output logic                  fault,
    output logic [2:0]            state,
    output logic [W_INSTRET-1:0]  instret
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    state_t st;
    logic   is_store;
    logic   wb_wen;

`ifdef SEQ_WDOG_EN
    localparam int CW = ($clog2(MEM_TIMEOUT + 1) > 8) ? $clog2(MEM_TIMEOUT + 1) : 8;
    logic [CW-1:0] wait_cnt;
    logic          fault_q;
    logic          wdog_hit;

    assign wdog_hit = (wait_cnt == CW'(MEM_TIMEOUT - 1));
    assign fault    = fault_q;
`else
    assign fault = 1'b0;
`endif

    // Store/write-back qualifiers are captured in EXEC so MEM/WB strobes stay Moore.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= IDLE;
            is_store <= 1'b0;
            wb_wen   <= 1'b0;
            instret  <= '0;
`ifdef SEQ_WDOG_EN
            wait_cnt <= '0;
            fault_q  <= 1'b0;
`endif
        end else begin
            unique case (st)
                IDLE: begin
                    if (run) st <= FETCH;
`ifdef SEQ_WDOG_EN
                    wait_cnt <= '0;
`endif
                end
                FETCH: begin
                    if (imem_ready) begin
                        st <= DECODE;
`ifdef SEQ_WDOG_EN
                    end else if (wdog_hit) begin
                        st      <= HALT;
                        fault_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                DECODE: st <= halt_dec ? HALT : EXEC;
                EXEC: begin
                    is_store <= (mem_cmd == `MEM_WRITE);
                    wb_wen   <= reg_wen_dec && (mem_cmd != `MEM_WRITE);
                    st       <= (mem_cmd == `MEM_NOP) ? WB : MEM;
`ifdef SEQ_WDOG_EN
                    wait_cnt <= '0;
`endif
                end
                MEM: begin
                    if (dmem_ready) begin
                        st <= WB;
`ifdef SEQ_WDOG_EN
                    end else if (wdog_hit) begin
                        st      <= HALT;
                        fault_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                WB: begin
                    instret <= instret + W_INSTRET'(1);
                    st      <= run ? FETCH : IDLE;
`ifdef SEQ_WDOG_EN
                    wait_cnt <= '0;
`endif
                end
                HALT: st <= HALT;
                default: begin
                    st <= HALT;
`ifdef SEQ_WDOG_EN
                    fault_q <= 1'b1;
`endif
                end
            endcase
        end
    end

    assign state    = st;
    assign imem_req = (st == FETCH);
    assign ir_en    = (st == FETCH) && imem_ready;
    assign dmem_req = (st == MEM);
    assign dmem_we  = (st == MEM) && is_store;
    assign pc_en    = (st == WB);
    assign reg_wen  = (st == WB) && wb_wen;
    assign halted   = (st == HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench for cpu_sequencer: a per-cycle trace is built from
// instruction descriptions and replayed against the DUT.
`ifndef W_MEM_CMD
`define W_MEM_CMD 2
`define MEM_NOP   2'd0
`define MEM_READ  2'd1
`define MEM_WRITE 2'd2
`define WREN      1'b1
`define WDIS      1'b0
`endif

module tb_cpu_sequencer;

    localparam int WI  = 4;
    localparam int TMO = 6;
`ifdef SEQ_WDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  run;
    logic                  halt_dec;
    logic [`W_MEM_CMD-1:0] mem_cmd;
    logic                  reg_wen_dec;
    logic                  imem_ready;
    logic                  dmem_ready;
    logic                  imem_req;
    logic                  dmem_req;
    logic                  dmem_we;
    logic                  ir_en;
    logic                  pc_en;
    logic                  reg_wen;
    logic                  halted;
    logic                  fault;
    logic [2:0]            state;
    logic [WI-1:0]         instret;

    cpu_sequencer #(
        .W_INSTRET(WI)
`ifdef SEQ_WDOG_EN
        ,
        .MEM_TIMEOUT(TMO)
`endif
    ) dut (
        .clk(clk), .rst(rst), .run(run), .halt_dec(halt_dec),
        .mem_cmd(mem_cmd), .reg_wen_dec(reg_wen_dec),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_en(ir_en), .pc_en(pc_en), .reg_wen(reg_wen),
        .halted(halted), .fault(fault), .state(state), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  s;
        logic        run;
        logic        hd;
        logic        ir;
        logic        dr;
        logic [1:0]  mc;
        logic        rwd;
        logic [10:0] exp;
    } cyc_t;

    cyc_t          q[$];
    int            n_chk = 0;
    int            n_pass = 0;
    logic [WI-1:0] cnt;
    logic [1:0]    cur_mc;
    logic          cur_rwd;
    bit            in_idle;

    wire [10:0] obs = {state, imem_req, dmem_req, dmem_we, ir_en,
                       pc_en, reg_wen, halted, fault};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [10:0] expv(input logic [2:0] s, input logic ir,
                                         input logic [1:0] mc, input logic rwd,
                                         input logic flt);
        return {s, s == 3'd1, s == 3'd4, (s == 3'd4) && (mc == `MEM_WRITE),
                (s == 3'd1) && ir, s == 3'd5,
                (s == 3'd5) && rwd && (mc != `MEM_WRITE), s == 3'd6, flt};
    endfunction

    task automatic push(input logic [2:0] s, input logic r, input logic hd,
                        input logic ir, input logic dr, input logic flt);
        cyc_t c;
        c.s = s; c.run = r; c.hd = hd; c.ir = ir; c.dr = dr;
        c.mc = cur_mc; c.rwd = cur_rwd;
        c.exp = expv(s, ir, cur_mc, cur_rwd, flt);
        q.push_back(c);
    endtask

    // One instruction: iw fetch waits, dw data waits, idle_n idle cycles first.
    task automatic gen(input logic [1:0] mc, input logic rwd, input int iw,
                       input int dw, input int idle_n, input logic wb_run,
                       input logic brk);
        cur_mc = mc;
        cur_rwd = rwd;
        if (in_idle) begin
            for (int k = 0; k < idle_n; k++) push(3'd0, 1'b0, rb(), rb(), rb(), 1'b0);
            push(3'd0, 1'b1, rb(), rb(), rb(), 1'b0);
        end
        for (int i = 0; i < iw; i++) push(3'd1, rb(), rb(), 1'b0, rb(), 1'b0);
        push(3'd1, rb(), rb(), 1'b1, rb(), 1'b0);
        push(3'd2, rb(), brk, rb(), rb(), 1'b0);
        if (brk) begin
            for (int i = 0; i < 5; i++) push(3'd6, rb(), rb(), rb(), rb(), 1'b0);
            in_idle = 1'b0;
        end else begin
            push(3'd3, rb(), rb(), rb(), rb(), 1'b0);
            if (mc != `MEM_NOP) begin
                for (int i = 0; i < dw; i++) push(3'd4, rb(), rb(), rb(), 1'b0, 1'b0);
                push(3'd4, rb(), rb(), rb(), 1'b1, 1'b0);
            end
            push(3'd5, wb_run, rb(), rb(), rb(), 1'b0);
            in_idle = !wb_run;
        end
    endtask

    task automatic play(input int lim);
        cyc_t c;
        int   n = 0;
        while (q.size() > 0 && n < lim) begin
            c = q.pop_front();
            @(negedge clk);
            run = c.run; halt_dec = c.hd; imem_ready = c.ir;
            dmem_ready = c.dr; mem_cmd = c.mc; reg_wen_dec = c.rwd;
            #1;
            chk("cyc", 32'(obs), 32'(c.exp));
            chk("instret", 32'(instret), 32'(cnt));
            if (c.s == 3'd5) cnt = cnt + 1'b1;
            n++;
        end
        q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; run = 1'b1;
        imem_ready = rb(); dmem_ready = rb();
        #1;
        chk("rst_out", 32'(obs), 32'd0);
        chk("rst_instret", 32'(instret), 32'd0);
        @(negedge clk);
        chk("rst_hold", 32'(obs), 32'd0);
        rst = 1'b0; run = 1'b0;
        cnt = '0;
        in_idle = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] mc;
        rst = 1'b1; run = 1'b0; halt_dec = 1'b0; mem_cmd = `MEM_NOP;
        reg_wen_dec = `WDIS; imem_ready = 1'b0; dmem_ready = 1'b0;
        do_reset();

        // ADDU, LW with 3 data waits, SW with WREN
        gen(`MEM_NOP, `WREN, 0, 0, 0, 1'b1, 1'b0);
        gen(`MEM_READ, `WREN, 0, 3, 0, 1'b1, 1'b0);
        gen(`MEM_WRITE, `WREN, 0, 0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            mc = 2'($urandom_range(0, 2));
            gen(mc, rb(), $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 2), $urandom_range(0, 3) != 0, 1'b0);
        end
        gen(`MEM_NOP, `WREN, 1, 0, 1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) push(3'd0, 1'b0, rb(), rb(), rb(), 1'b0);
        play(100000);

        // BREAK halts without retiring; only reset leaves HALT
        gen(`MEM_NOP, `WREN, 1, 0, 1, 1'b1, 1'b1);
        play(100000);
        do_reset();

        // reset in the middle of a load abandons the request
        gen(`MEM_READ, `WREN, 0, 3, 0, 1'b1, 1'b0);
        play(6);
        do_reset();

        // fetch that never completes
        cur_mc = `MEM_NOP; cur_rwd = `WREN;
        push(3'd0, 1'b1, rb(), rb(), rb(), 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (WDOG && i >= TMO) push(3'd6, rb(), rb(), 1'b0, rb(), 1'b1);
            else push(3'd1, rb(), rb(), 1'b0, rb(), 1'b0);
        end
        play(100000);
        do_reset();

        // data access that never completes
        cur_mc = `MEM_READ; cur_rwd = `WREN;
        push(3'd0, 1'b1, rb(), rb(), rb(), 1'b0);
        push(3'd1, rb(), rb(), 1'b1, rb(), 1'b0);
        push(3'd2, rb(), 1'b0, rb(), rb(), 1'b0);
        push(3'd3, rb(), rb(), rb(), rb(), 1'b0);
        for (int i = 0; i < 40; i++) begin
            if (WDOG && i >= TMO) push(3'd6, rb(), rb(), rb(), 1'b0, 1'b1);
            else push(3'd4, rb(), rb(), rb(), 1'b0, 1'b0);
        end
        play(100000);
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle control sequencer for the MIPS core. It steps each instruction through fetch, decode, execute, memory and writeback. It handshakes with instruction and data memory and gates the decoder's register-write and memory commands so they take effect only in the correct cycle. It sits between the decoder, the PC/IR registers, the register file and the memory ports, and provides halt, fault and retired-instruction status.

## Interface
- W_INSTRET, 32, width of retired-instruction counter
- MEM_TIMEOUT, 255, max wait cycles on a memory request before fault (watchdog builds only)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = fetch new instructions
- halt_dec  in  1  decoder reports SYSCALL or BREAK for the current instruction
- mem_cmd  in  `W_MEM_CMD  decoder memory command (`MEM_NOP / `MEM_READ / `MEM_WRITE)
- reg_wen_dec  in  1  decoder register write enable (`WREN / `WDIS)
- imem_ready  in  1  instruction memory data valid / accepted
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write strobe
- ir_en  out  1  load instruction register
- pc_en  out  1  update PC from the selected pc_src
- reg_wen  out  1  gated register file write enable
- halted  out  1  sticky halt indicator
- fault  out  1  sticky memory-timeout indicator
- state  out  3  current state, for debug
- instret  out  W_INSTRET  retired-instruction count

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6. Encodings 7 and up are illegal and go to HALT with fault=1.
- IDLE: all strobes 0. If run=1, go to FETCH.
- FETCH: imem_req=1. When imem_ready=1, ir_en=1 for that cycle and go to DECODE. Otherwise stay in FETCH.
- DECODE: one cycle. If halt_dec=1, go to HALT. Otherwise go to EXEC.
- EXEC: one cycle, ALU settles. If mem_cmd=`MEM_NOP, go to WB. Otherwise go to MEM.
- MEM: dmem_req=1 and dmem_we=(mem_cmd==`MEM_WRITE). When dmem_ready=1, go to WB. Otherwise stay in MEM.
- WB: pc_en=1 and instret increments.
  - reg_wen = reg_wen_dec AND (mem_cmd != `MEM_WRITE). Stores never write the register file, even though the decoder asserts `WREN for SW.
  - Next state is FETCH if run=1, else IDLE.
- HALT: halted=1; every other strobe is 0. Only reset exits HALT.
- instret wraps modulo 2^W_INSTRET. It does not saturate.

## Timing
- Reset (async assert, synchronous-safe deassert at the next clk edge) sets: state=IDLE, halted=0, fault=0, instret=0. All request and strobe outputs are 0 while rst=1.
- All outputs except ir_en decode from the state register only (Moore). ir_en = (state==FETCH) AND imem_ready (Mealy).
- Ready inputs are sampled at the rising edge while the request is high. Ready arriving in the same cycle as the request counts, giving zero wait states.
- Latency with zero wait states:
  - non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB)
  - load or store: 5 cycles
  - each wait cycle adds 1
- imem_req and dmem_req stay high continuously until their ready is seen. Requests never drop mid-handshake.
- run deasserted mid-instruction: the current instruction completes through WB, then the block enters IDLE. run is sampled only in IDLE and WB.
- halt_dec is sampled only in DECODE. A halted instruction never reaches WB, so pc_en stays 0 and instret does not count it.
- Reset mid-operation: an outstanding request is abandoned immediately and no WB side effects occur.

## Configuration
- SEQ_WDOG_EN defined:
  - An 8-bit-or-wider wait counter clears on entry to FETCH or MEM and increments each cycle ready=0.
  - When it reaches MEM_TIMEOUT with ready still 0, the request drops and the block enters HALT with fault=1 (sticky until reset).
- SEQ_WDOG_EN undefined: no counter, the block waits indefinitely, and fault is tied 0 (illegal state still routes to HALT).

## Test plan
- Reset, run=1, imem_ready=dmem_ready=1, ADDU with reg_wen_dec=1, mem_cmd=NOP -> states 1,2,3,5; reg_wen and pc_en high only in cycle 4; instret=1.
- LW with dmem_ready delayed 3 cycles -> MEM held 4 cycles with dmem_req=1, dmem_we=0; reg_wen=1 in WB; 8 cycles total.
- SW with reg_wen_dec=1 -> dmem_we=1 in MEM; reg_wen=0 in WB; pc_en=1.
- BREAK (halt_dec=1 in DECODE) -> state=6, halted=1, pc_en never asserted, instret unchanged; holds until rst pulse, after which state=0 and halted=0.
- run dropped during EXEC of the 2nd instruction -> WB completes, instret=2, state=0, imem_req stays 0.
- SEQ_WDOG_EN build, MEM_TIMEOUT=4, imem_ready held 0 -> after 4 wait cycles state=6, fault=1, imem_req=0. Non-watchdog build: FETCH held indefinitely, fault=0.
